// File: rtl/frame_buffer_multi.sv
// Decimating camera frame store with double/triple banking on one clock.
// Writer commits only complete frames; the reader swaps banks only at its own start-of-frame.
`timescale 1ns/1ps
module frame_buffer_multi #(
  parameter int unsigned IN_WIDTH   = 640,
  parameter int unsigned IN_HEIGHT  = 480,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned PIXEL_BITS = 12,
  parameter int unsigned NUM_BUFS   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_sof,
  input  logic                  i_eof,
  input  logic                  i_pixel_valid,
  input  logic [15:0]           i_pixel_data,
  input  logic                  i_rd_sof,
  input  logic                  i_rd_req,
  input  logic [9:0]            i_rd_x,
  input  logic [8:0]            i_rd_y,
  output logic                  o_rd_valid,
  output logic [PIXEL_BITS-1:0] o_rd_data,
  output logic                  o_frame_ready,
  output logic [1:0]            o_wr_buf,
  output logic [1:0]            o_rd_buf,
  output logic                  o_short_frame,
  output logic [7:0]            o_drop_count
);

  localparam int unsigned OutW      = IN_WIDTH >> SCALE_LOG2;
  localparam int unsigned OutH      = IN_HEIGHT >> SCALE_LOG2;
  localparam int unsigned BankWords = OutW * OutH;
  localparam int unsigned Depth     = NUM_BUFS * BankWords;
  localparam int unsigned Total     = IN_WIDTH * IN_HEIGHT;
  localparam int unsigned DecMask   = (1 << SCALE_LOG2) - 1;
  localparam int unsigned AW        = $clog2(Depth);
  localparam int unsigned XW        = $clog2(IN_WIDTH);
  localparam int unsigned YW        = $clog2(IN_HEIGHT + 1);
  localparam int unsigned CW        = $clog2(Total + 1);

  typedef enum logic [0:0] {StIdle, StCap} wr_state_e;

  wr_state_e       state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovl_q, ovl_d;
  logic [1:0]      wr_buf_q, wr_buf_d;
  logic [1:0]      rd_buf_q, rd_buf_d;
  logic [1:0]      pending_buf_q, pending_buf_d;
  logic            pending_q, pending_d;
  logic            frame_ready_q, frame_ready_d;
  logic            short_q, short_d;
  logic [7:0]      drop_q, drop_d;
  logic            drop_inc;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [PIXEL_BITS-1:0] wr_data;
  logic            x_keep, y_keep;
  logic            swap;
  logic [1:0]      rd_buf_sw;
  logic [1:0]      free_buf;

  logic            rd_req_q, rd_valid_q;
  logic            rd_zero_q, rd_zero_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [PIXEL_BITS-1:0] rd_data_q;
  logic            rd_oob;

  logic [PIXEL_BITS-1:0] mem [Depth];

  logic unused_pix;
  assign unused_pix = ^i_pixel_data;

  assign x_keep  = (x_q & XW'(DecMask)) == '0;
  assign y_keep  = (y_q & YW'(DecMask)) == '0;
  assign wr_data = i_pixel_data[15 -: PIXEL_BITS];
  assign wr_addr = AW'(wr_buf_q) * AW'(BankWords) + AW'(y_q >> SCALE_LOG2) * AW'(OutW)
                 + AW'(x_q >> SCALE_LOG2);

  // Swap sees only the pending state from before any commit in the same cycle
  assign swap      = i_rd_sof && pending_q;
  assign rd_buf_sw = swap ? pending_buf_q : rd_buf_q;

  // Triple buffering: lowest bank that is neither being read nor holding the pending frame
  always_comb begin
    free_buf = 2'd0;
    for (int b = 2; b >= 0; b--) begin
      if (2'(b) != rd_buf_sw && 2'(b) != pending_buf_q) free_buf = 2'(b);
    end
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    cnt_d         = cnt_q;
    ovl_d         = ovl_q;
    wr_buf_d      = wr_buf_q;
    rd_buf_d      = rd_buf_sw;
    pending_d     = pending_q;
    pending_buf_d = pending_buf_q;
    frame_ready_d = frame_ready_q;
    short_d       = 1'b0;
    drop_inc      = 1'b0;
    wr_en         = 1'b0;

    if (swap) begin
      pending_d     = 1'b0;
      frame_ready_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_sof) begin
          state_d = StCap;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          ovl_d   = 1'b0;
          if (NUM_BUFS == 3) begin
            wr_buf_d = free_buf;
          end else begin
            wr_buf_d = {1'b0, ~rd_buf_sw[0]};
            if (pending_d) begin
              pending_d = 1'b0;
              drop_inc  = 1'b1;
            end
          end
        end
      end
      StCap: begin
        if (i_sof) begin
          x_d   = '0;
          y_d   = '0;
          cnt_d = '0;
          ovl_d = 1'b0;
        end else begin
          if (i_pixel_valid) begin
            if (cnt_q == CW'(Total)) begin
              ovl_d = 1'b1;
            end else begin
              wr_en = x_keep && y_keep;
              cnt_d = cnt_q + CW'(1);
              if (x_q == XW'(IN_WIDTH - 1)) begin
                x_d = '0;
                y_d = y_q + YW'(1);
              end else begin
                x_d = x_q + XW'(1);
              end
            end
          end
          if (i_eof) begin
            state_d = StIdle;
            if (!ovl_d && cnt_d == CW'(Total)) begin
              if (pending_d) drop_inc = 1'b1;
              pending_d     = 1'b1;
              pending_buf_d = wr_buf_q;
            end else begin
              short_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    drop_d = (drop_inc && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
  end

  assign rd_oob    = (32'(i_rd_x) >= OutW) || (32'(i_rd_y) >= OutH);
  assign rd_zero_d = rd_oob || !frame_ready_q;
  assign rd_addr_d = rd_oob ? '0 :
                     AW'(rd_buf_q) * AW'(BankWords) + AW'(i_rd_y) * AW'(OutW) + AW'(i_rd_x);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      cnt_q         <= '0;
      ovl_q         <= 1'b0;
      wr_buf_q      <= 2'd1;
      rd_buf_q      <= 2'd0;
      pending_q     <= 1'b0;
      pending_buf_q <= 2'd0;
      frame_ready_q <= 1'b0;
      short_q       <= 1'b0;
      drop_q        <= 8'd0;
      rd_req_q      <= 1'b0;
      rd_zero_q     <= 1'b0;
      rd_addr_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      cnt_q         <= cnt_d;
      ovl_q         <= ovl_d;
      wr_buf_q      <= wr_buf_d;
      rd_buf_q      <= rd_buf_d;
      pending_q     <= pending_d;
      pending_buf_q <= pending_buf_d;
      frame_ready_q <= frame_ready_d;
      short_q       <= short_d;
      drop_q        <= drop_d;
      rd_req_q      <= i_rd_req;
      rd_zero_q     <= rd_zero_d;
      rd_addr_q     <= rd_addr_d;
      rd_valid_q    <= rd_req_q;
      rd_data_q     <= rd_zero_q ? '0 : mem[rd_addr_q];
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign o_rd_valid    = rd_valid_q;
  assign o_rd_data     = rd_data_q;
  assign o_frame_ready = frame_ready_q;
  assign o_wr_buf      = wr_buf_q;
  assign o_rd_buf      = rd_buf_q;
  assign o_short_frame = short_q;
  assign o_drop_count  = drop_q;

endmodule

// File: tb/tb_frame_buffer_multi.sv
// Bench for frame_buffer_multi: a double- and a triple-buffered instance share one stimulus
// stream and are checked against a frame-level model of bank ownership and stored images.
`timescale 1ns/1ps
module tb_frame_buffer_multi;

  localparam int unsigned W     = 16;
  localparam int unsigned H     = 12;
  localparam int unsigned S     = 1;
  localparam int unsigned PB    = 12;
  localparam int unsigned OW    = W >> S;
  localparam int unsigned OH    = H >> S;
  localparam int unsigned TOTAL = W * H;

  localparam int SelValid = 0, SelData = 1, SelReady = 2, SelWr = 3, SelRd = 4, SelShort = 5,
                 SelDrop = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, sof, eof, pv, rd_sof, rd_req;
  logic [15:0]   pd;
  logic [9:0]    rx;
  logic [8:0]    ry;
  logic          valid2, valid3, ready2, ready3, short2, short3;
  logic [PB-1:0] data2, data3;
  logic [1:0]    wr2, wr3, rd2, rd3;
  logic [7:0]    drop2, drop3;

  frame_buffer_multi #(.IN_WIDTH(W), .IN_HEIGHT(H), .SCALE_LOG2(S), .PIXEL_BITS(PB),
                       .NUM_BUFS(2)) u_dut2 (
    .i_clk(clk), .i_rstn(rstn), .i_sof(sof), .i_eof(eof), .i_pixel_valid(pv),
    .i_pixel_data(pd), .i_rd_sof(rd_sof), .i_rd_req(rd_req), .i_rd_x(rx), .i_rd_y(ry),
    .o_rd_valid(valid2), .o_rd_data(data2), .o_frame_ready(ready2), .o_wr_buf(wr2),
    .o_rd_buf(rd2), .o_short_frame(short2), .o_drop_count(drop2)
  );

  frame_buffer_multi #(.IN_WIDTH(W), .IN_HEIGHT(H), .SCALE_LOG2(S), .PIXEL_BITS(PB),
                       .NUM_BUFS(3)) u_dut3 (
    .i_clk(clk), .i_rstn(rstn), .i_sof(sof), .i_eof(eof), .i_pixel_valid(pv),
    .i_pixel_data(pd), .i_rd_sof(rd_sof), .i_rd_req(rd_req), .i_rd_x(rx), .i_rd_y(ry),
    .o_rd_valid(valid3), .o_rd_data(data3), .o_frame_ready(ready3), .o_wr_buf(wr3),
    .o_rd_buf(rd3), .o_short_frame(short3), .o_drop_count(drop3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state, index 0 = double-buffered instance, 1 = triple-buffered instance
  int m_rd[2], m_wr[2], m_pend[2], m_pbuf[2], m_ready[2], m_drop[2];
  int bank_id[2][3];
  logic [15:0] salt [8];
  int qx[$], qy[$];

  function automatic logic [15:0] pix(input int id, input int x, input int y);
    return 16'(int'(salt[id]) + x * 97 + y * 1277);
  endfunction

  function automatic logic [31:0] exp_read(input int k, input int x, input int y);
    logic [15:0] p;
    if (m_ready[k] == 0 || x >= int'(OW) || y >= int'(OH)) return 32'd0;
    p = pix(bank_id[k][m_rd[k]], x * 2, y * 2);
    return 32'(p >> (16 - PB));
  endfunction

  function automatic logic [31:0] dut_out(input int k, input int sel);
    logic [31:0] r;
    r = '0;
    case (sel)
      SelValid: r = 32'(k == 0 ? valid2 : valid3);
      SelData:  r = 32'(k == 0 ? data2 : data3);
      SelReady: r = 32'(k == 0 ? ready2 : ready3);
      SelWr:    r = 32'(k == 0 ? wr2 : wr3);
      SelRd:    r = 32'(k == 0 ? rd2 : rd3);
      SelShort: r = 32'(k == 0 ? short2 : short3);
      SelDrop:  r = 32'(k == 0 ? drop2 : drop3);
      default:  r = '1;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass += 1;
    else $error("FAIL %s bufs%0d: observed %0d required %0d", tag, k + 2, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rd[k] = 0; m_wr[k] = 1; m_pend[k] = 0; m_pbuf[k] = 0; m_ready[k] = 0; m_drop[k] = 0;
    end
  endtask

  task automatic model_swap(input int k);
    if (m_pend[k] != 0) begin
      m_rd[k] = m_pbuf[k]; m_pend[k] = 0; m_ready[k] = 1;
    end
  endtask

  task automatic model_sof();
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        m_wr[k] = (m_rd[k] != m_pbuf[k]) ? 3 - m_rd[k] - m_pbuf[k] : (m_rd[k] == 0 ? 1 : 0);
      end else begin
        m_wr[k] = 1 - m_rd[k];
        if (m_pend[k] != 0) begin
          m_pend[k] = 0;
          if (m_drop[k] < 255) m_drop[k]++;
        end
      end
    end
  endtask

  task automatic model_commit(input int fid, input bit with_rd_sof);
    for (int k = 0; k < 2; k++) begin
      if (with_rd_sof) model_swap(k);
      if (m_pend[k] != 0 && m_drop[k] < 255) m_drop[k]++;
      bank_id[k][m_wr[k]] = fid;
      m_pend[k] = 1;
      m_pbuf[k] = m_wr[k];
    end
  endtask

  task automatic chk_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, ".rd_buf"}, k, dut_out(k, SelRd), 32'(m_rd[k]));
      chk({tag, ".wr_buf"}, k, dut_out(k, SelWr), 32'(m_wr[k]));
      chk({tag, ".frame_ready"}, k, dut_out(k, SelReady), 32'(m_ready[k]));
      chk({tag, ".drop_count"}, k, dut_out(k, SelDrop), 32'(m_drop[k]));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, ".rd_valid"}, k, dut_out(k, SelValid), 32'd0);
      chk({tag, ".rd_data"}, k, dut_out(k, SelData), 32'd0);
      chk({tag, ".frame_ready"}, k, dut_out(k, SelReady), 32'd0);
      chk({tag, ".wr_buf"}, k, dut_out(k, SelWr), 32'd1);
      chk({tag, ".rd_buf"}, k, dut_out(k, SelRd), 32'd0);
      chk({tag, ".short"}, k, dut_out(k, SelShort), 32'd0);
      chk({tag, ".drop"}, k, dut_out(k, SelDrop), 32'd0);
    end
  endtask

  task automatic pulse_rd_sof(input string tag);
    rd_sof = 1'b1;
    step();
    rd_sof = 1'b0;
    for (int k = 0; k < 2; k++) model_swap(k);
    chk_state(tag);
  endtask

  task automatic add_rd(input int x, input int y);
    qx.push_back(x);
    qy.push_back(y);
  endtask

  task automatic add_random_reads(input int n);
    for (int i = 0; i < n; i++) add_rd(int'($urandom_range(0, OW - 1)),
                                       int'($urandom_range(0, OH - 1)));
  endtask

  // Issues the queued reads back to back and checks one result per cycle, 2 cycles late
  task automatic read_burst(input string tag);
    int n;
    logic [31:0] e2[$], e3[$];
    n = qx.size();
    rd_req = 1'b0;
    step();
    step();
    for (int c = 0; c <= n; c++) begin
      if (c < n) begin
        rd_req = 1'b1;
        rx = 10'(qx[c]);
        ry = 9'(qy[c]);
        e2.push_back(exp_read(0, qx[c], qy[c]));
        e3.push_back(exp_read(1, qx[c], qy[c]));
      end else begin
        rd_req = 1'b0;
      end
      step();
      if (c == 0) begin
        for (int k = 0; k < 2; k++) chk({tag, ".early_valid"}, k, dut_out(k, SelValid), 32'd0);
      end else begin
        for (int k = 0; k < 2; k++) chk({tag, ".valid"}, k, dut_out(k, SelValid), 32'd1);
        chk({tag, ".data"}, 0, dut_out(0, SelData), e2.pop_front());
        chk({tag, ".data"}, 1, dut_out(1, SelData), e3.pop_front());
      end
    end
    step();
    for (int k = 0; k < 2; k++) chk({tag, ".valid_end"}, k, dut_out(k, SelValid), 32'd0);
    qx.delete();
    qy.delete();
  endtask

  task automatic send_frame(input string tag, input int fid, input int npix,
                            input int restart_at, input bit rdsof_eof);
    int  n;
    bit  restarted, together, full;
    n = 0;
    restarted = 1'b0;
    together = 1'b0;
    full = (npix == int'(TOTAL));
    // A stray strobe while idle must be ignored
    pv = 1'b1;
    pd = 16'($urandom);
    step();
    pv = 1'b0;
    sof = 1'b1;
    step();
    sof = 1'b0;
    model_sof();
    for (int k = 0; k < 2; k++) chk({tag, ".wr_at_sof"}, k, dut_out(k, SelWr), 32'(m_wr[k]));
    while (n < npix) begin
      if (restart_at > 0 && !restarted && n == restart_at) begin
        pv = 1'b0;
        sof = 1'b1;
        step();
        sof = 1'b0;
        restarted = 1'b1;
        n = 0;
        step();
        for (int k = 0; k < 2; k++) chk({tag, ".restart_short"}, k, dut_out(k, SelShort), 32'd0);
        continue;
      end
      if ($urandom_range(0, 3) == 0) begin
        pv = 1'b0;
        step();
        continue;
      end
      pv = 1'b1;
      pd = pix(fid, n % int'(W), n / int'(W));
      if (n == npix - 1 && $urandom_range(0, 1) == 1) begin
        eof = 1'b1;
        rd_sof = rdsof_eof;
        together = 1'b1;
      end
      step();
      n++;
    end
    pv = 1'b0;
    if (!together) begin
      eof = 1'b1;
      rd_sof = rdsof_eof;
      step();
    end
    eof = 1'b0;
    rd_sof = 1'b0;
    if (full) model_commit(fid, rdsof_eof);
    else if (rdsof_eof) for (int k = 0; k < 2; k++) model_swap(k);
    for (int k = 0; k < 2; k++) chk({tag, ".short"}, k, dut_out(k, SelShort), 32'(!full));
    step();
    for (int k = 0; k < 2; k++) chk({tag, ".short_end"}, k, dut_out(k, SelShort), 32'd0);
    chk_state(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; sof = 1'b0; eof = 1'b0; pv = 1'b0; pd = '0;
    rd_sof = 1'b0; rd_req = 1'b0; rx = '0; ry = '0;
    for (int i = 0; i < 8; i++) salt[i] = 16'($urandom);
    for (int k = 0; k < 2; k++) for (int b = 0; b < 3; b++) bank_id[k][b] = 0;
    model_reset();
    repeat (3) step();
    chk_reset_outputs("reset");
    rstn = 1'b1;
    step();

    add_rd(3, 2);
    add_rd(0, 0);
    read_burst("no_frame");

    send_frame("t1", 0, TOTAL, 0, 1'b0);
    pulse_rd_sof("t1_swap");
    add_rd(5, 3);
    add_random_reads(5);
    read_burst("t1_read");

    send_frame("t2_short", 1, 100, 0, 1'b0);
    pulse_rd_sof("t2_swap");
    send_frame("overlong", 1, TOTAL + 5, 0, 1'b0);
    pulse_rd_sof("overlong_swap");
    add_rd(0, 0);
    add_random_reads(3);
    read_burst("t2_read");

    send_frame("t34_f1", 1, TOTAL, 0, 1'b0);
    send_frame("t34_f2", 2, TOTAL, 0, 1'b0);
    send_frame("t34_f3", 3, TOTAL, 0, 1'b0);
    pulse_rd_sof("t34_swap");
    add_random_reads(6);
    read_burst("t34_read");

    send_frame("restart", 4, TOTAL, 50, 1'b0);
    pulse_rd_sof("restart_swap");
    add_rd(int'(OW) - 1, int'(OH) - 1);
    add_random_reads(3);
    read_burst("restart_read");

    add_rd(int'(OW), 0);
    add_rd(0, int'(OH));
    add_rd(2, 1);
    add_rd(int'(OW) - 1, 0);
    read_burst("t5_bounds");

    send_frame("commit_rdsof", 5, TOTAL, 0, 1'b1);
    add_random_reads(2);
    read_burst("commit_rdsof_old");
    pulse_rd_sof("commit_rdsof_swap");
    add_random_reads(3);
    read_burst("commit_rdsof_new");

    sof = 1'b1;
    step();
    sof = 1'b0;
    pv = 1'b1;
    for (int i = 0; i < 30; i++) begin
      pd = 16'($urandom);
      step();
    end
    #2;
    rstn = 1'b0;
    pv = 1'b0;
    #1;
    chk_reset_outputs("t6_in_reset");
    step();
    chk_reset_outputs("t6_in_reset_clk");
    rstn = 1'b1;
    model_reset();
    step();
    chk_state("t6_after");
    add_rd(1, 1);
    read_burst("t6_masked");
    send_frame("t6_frame", 7, TOTAL, 0, 1'b0);
    pulse_rd_sof("t6_swap");
    add_random_reads(4);
    read_burst("t6_read");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
